// File: rtl/gpu_pkg.sv
// Shared defaults for the GPU return-path blocks: pipeline latency, data width
// and the minimum buffer depth that still allows one issue per cycle.
package gpu_pkg;

  localparam int DEFAULT_LATENCY = 5;
  localparam int DEFAULT_WIDTH   = 8;

  // One slot per in-flight beat, plus one for the registered head and one
  // for the cycle a returned credit takes to reach issue_ready_o.
  function automatic int min_full_rate_depth(input int latency);
    return latency + 2;
  endfunction

endpackage

// File: rtl/return_fifo.sv
// Synchronous FIFO with modulo-DEPTH pointers (any DEPTH, not just powers of two).
// The head is visible one cycle after its write; there is no write-to-read bypass.
module return_fifo
  import gpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = min_full_rate_depth(DEFAULT_LATENCY)
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             do_wr_s;
  logic             do_rd_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1'b1);
    end
  endfunction

  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign do_rd_s = rd_en & (count_r != {CNT_W{1'b0}});
  // When full, a write is only legal because the simultaneous read frees the head slot.
  assign do_wr_s = wr_en & (~full_s | do_rd_s);

  // Storage array; the head read below sees the old contents on a same-slot write.
  always_ff @(posedge clk_i) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_rd_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head data is forced to zero while empty so reset and idle look identical.
  always_comb begin
    rd_valid = (count_r != {CNT_W{1'b0}});
    rd_data  = {WIDTH{1'b0}};
    if (rd_valid) begin
      rd_data = mem_r[rd_ptr_r];
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/latency_return_buffer.sv
// Credit-controlled landing buffer for a fixed-latency pipeline: issues are only
// accepted while a buffer slot is guaranteed for the beat that returns LATENCY cycles later.
module latency_return_buffer
  import gpu_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH   = min_full_rate_depth(LATENCY)
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic                       ret_valid_i,
  input  logic [WIDTH-1:0]           ret_data_i,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  if (LATENCY < 1 || LATENCY > 64) begin : g_bad_latency
    $error("latency_return_buffer: LATENCY must be within 1..64");
  end
  if (DEPTH < 1 || DEPTH > 128) begin : g_bad_depth
    $error("latency_return_buffer: DEPTH must be within 1..128");
  end

  logic [CNT_W-1:0] credits_r;
  logic [CNT_W-1:0] fifo_count_s;
  logic [WIDTH-1:0] fifo_data_s;
  logic             fifo_valid_s;
  logic             accept_s;
  logic             pop_s;
  logic             full_s;
  logic             fifo_wr_s;
  logic             overflow_r;

  assign issue_ready_o = (credits_r != {CNT_W{1'b0}});
  assign accept_s      = issue_valid_i & issue_ready_o;
  assign pop_s         = fifo_valid_s & out_ready_i;
  assign full_s        = (fifo_count_s == CNT_W'(DEPTH));
  // Returns are never back-pressured; a beat with nowhere to land is dropped.
  assign fifo_wr_s     = ret_valid_i & (~full_s | pop_s);

  // Credit counter: one credit per buffer slot, consumed on issue, returned on pop.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      credits_r <= CNT_W'(DEPTH);
    end else begin
      case ({accept_s, pop_s})
        2'b10: begin
          if (credits_r != {CNT_W{1'b0}}) begin
            credits_r <= credits_r - CNT_W'(1'b1);
          end
        end
        2'b01: begin
          if (credits_r != CNT_W'(DEPTH)) begin
            credits_r <= credits_r + CNT_W'(1'b1);
          end
        end
        default: credits_r <= credits_r;
      endcase
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      overflow_r <= 1'b0;
    end else if (ret_valid_i && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end
  end

  return_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .wr_en    (fifo_wr_s),
    .wr_data  (ret_data_i),
    .rd_en    (out_ready_i),
    .rd_valid (fifo_valid_s),
    .rd_data  (fifo_data_s),
    .count    (fifo_count_s)
  );

  assign out_valid_o = fifo_valid_s;
  assign out_data_o  = fifo_data_s;
  assign count_o     = fifo_count_s;
  assign overflow_o  = overflow_r;

endmodule

// File: doc/latency_return_buffer.md
LATENCY_RETURN_BUFFER -- requirements
Module: latency_return_buffer

Interface
REQ-001 The block SHALL have parameter LATENCY, default 5: fixed cycles from an accepted issue to its return beat on ret_valid_i (range 1..64).
REQ-002 The block SHALL have parameter WIDTH, default 8: return data width in bits.
REQ-003 The block SHALL have parameter DEPTH, default LATENCY+2: buffer entries, which equals the number of credits (range 1..128).
REQ-004 The block SHALL have clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have reset_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have issue_valid_i, input, 1 bit: upstream requests to launch one operation into the fixed-latency pipeline.
REQ-007 The block SHALL have issue_ready_o, output, 1 bit: a credit is available; an issue is accepted when issue_valid_i and issue_ready_o are both high.
REQ-008 The block SHALL have ret_valid_i, input, 1 bit: a return beat is present, exactly LATENCY cycles after its accepted issue.
REQ-009 The block SHALL have ret_data_i, input, WIDTH bits: the return payload.
REQ-010 The block SHALL have out_valid_o, output, 1 bit: the buffer head is valid.
REQ-011 The block SHALL have out_data_o, output, WIDTH bits: the buffer head data.
REQ-012 The block SHALL have out_ready_i, input, 1 bit: the consumer accepts; a pop occurs when out_valid_o and out_ready_i are both high.
REQ-013 The block SHALL have count_o, output, $clog2(DEPTH+1) bits: the number of occupied entries.
REQ-014 The block SHALL have overflow_o, output, 1 bit: sticky error, set by a return beat that arrives while the buffer is full.

Function
REQ-015 The credit counter SHALL reset to DEPTH, decrement on an accepted issue, increment on a pop, and hold when both occur in the same cycle.
REQ-016 issue_ready_o SHALL be combinationally (credits != 0); the credit counter SHALL never go below 0 or above DEPTH.
REQ-017 A ret_valid_i beat SHALL be written at the tail on that clock edge, with no backpressure toward the return path.
REQ-018 out_valid_o/out_data_o SHALL reflect a written beat on the cycle after the write (first-word latency 1); out_data_o is registered or RAM-read, with no combinational path from ret_data_i.
REQ-019 Order SHALL be strict FIFO: the return order equals the issue order equals the pop order.
REQ-020 A write and a pop in the same cycle SHALL both take effect and leave count_o unchanged; this SHALL hold at count 0 (no bypass; the output stays invalid that cycle) and at count DEPTH.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH, including non-power-of-two DEPTH.
REQ-022 out_data_o SHALL hold stable while out_valid_o is high and out_ready_i is low.
REQ-023 A return beat that arrives when count == DEPTH with no simultaneous pop SHALL be dropped and SHALL set overflow_o; overflow_o clears only on reset.
REQ-024 Throughput: with DEPTH >= LATENCY+2 and out_ready_i held high, the block SHALL sustain one issue per cycle indefinitely.
REQ-025 If DEPTH < LATENCY+2, the issue rate SHALL be DEPTH issues per LATENCY+2 cycles, and overflow_o SHALL never set.

Reset
REQ-026 While reset_ni is low: credits = DEPTH, pointers = 0, count_o = 0, out_valid_o = 0, overflow_o = 0, and out_data_o = 0.
REQ-027 On the first cycle after reset deassertion, issue_ready_o SHALL be 1.
REQ-028 An assertion of reset_ni mid-operation SHALL discard all buffered and in-flight state; the upstream pipeline shares reset_ni, so no stale returns arrive.

Structure
REQ-029 Shared package gpu_pkg SHALL hold DEFAULT_LATENCY (5) and DEFAULT_WIDTH (8), plus a function computing the minimum full-rate depth (LATENCY+2).
REQ-030 A single sub-module, return_fifo (synchronous FIFO: pointers, count, storage), is natural; credit logic and overflow detection stay in the top level.

Verification
REQ-031 Reset, then 10 back-to-back issues, return data 0x01..0x0A at LATENCY 5, out_ready_i high -> out_data_o 0x01..0x0A in order on consecutive cycles, issue_ready_o never low.
REQ-032 out_ready_i low, 8 issues at DEPTH 7 -> 7 issues accepted, issue_ready_o low afterwards; count_o reaches 7 five cycles after the last accepted issue; raising out_ready_i for one cycle -> issue_ready_o returns to 1 the next cycle.
REQ-033 count_o = 1 with head 0x55, a simultaneous pop and return of 0xAA -> count_o stays 1, out_data_o = 0xAA next cycle.
REQ-034 DEPTH 3, 20 issues with out_ready_i high -> the credit bound caps outstanding issues at 3; all 20 values are delivered in order; overflow_o stays 0.
REQ-035 Buffer full, ret_valid_i forced high with out_ready_i low -> beat dropped, overflow_o = 1 and remains 1 until reset_ni pulses low.
REQ-036 Mid-stream, with count_o = 4, reset_ni pulsed low asynchronously -> all outputs take their reset values immediately; credits = DEPTH after release.
